// File: rtl/osd_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM single-word read master between two OSD
// read engines; returned data is steered back through an in-order tag FIFO.
module osd_read_arbiter #(
    parameter int DATA_LOG = 3,
    parameter int PEND_LOG = 3,
    localparam int DW      = 1 << DATA_LOG,
    localparam int BW      = 1 << (DATA_LOG - 3),
    localparam int DEPTH   = 1 << PEND_LOG
) (
    input  logic                clk,
    input  logic                rst,

    input  logic [31:0]         s0_address,
    input  logic                s0_read,
    input  logic [BW-1:0]       s0_byteenable,
    output logic                s0_waitrequest,
    output logic [DW-1:0]       s0_readdata,
    output logic                s0_readdatavalid,

    input  logic [31:0]         s1_address,
    input  logic                s1_read,
    input  logic [BW-1:0]       s1_byteenable,
    output logic                s1_waitrequest,
    output logic [DW-1:0]       s1_readdata,
    output logic                s1_readdatavalid,

    output logic [31:0]         m_address,
    output logic                m_read,
    output logic [BW-1:0]       m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DW-1:0]       m_readdata,
    input  logic                m_readdatavalid,

    output logic [PEND_LOG:0]   pending,
    output logic                err_orphan,
    output logic [1:0]          arb_state
);

    // Handshake: a master-side read is accepted in the cycle where m_read=1 and
    // m_waitrequest=0; s*_waitrequest mirrors that only for the current owner.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCK0    = 2'd1,
        LOCK1    = 2'd2
    } state_t;

    localparam logic [PEND_LOG:0] FULL_CNT = {1'b1, {PEND_LOG{1'b0}}};

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic [PEND_LOG-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PEND_LOG:0]    count_q;
    logic [DEPTH-1:0]     tag_q;
    logic                 err_q;

    logic owner_vld;
    logic owner;
    logic owner_read;
    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic head;

    always_comb begin
        owner_vld = 1'b0;
        owner     = 1'b0;
        case (state_q)
            LOCK0: begin
                owner_vld = 1'b1;
                owner     = 1'b0;
            end
            LOCK1: begin
                owner_vld = 1'b1;
                owner     = 1'b1;
            end
            default: begin
                if (s0_read && s1_read) begin
                    owner_vld = 1'b1;
                    owner     = ~last_q;
                end else if (s0_read) begin
                    owner_vld = 1'b1;
                    owner     = 1'b0;
                end else if (s1_read) begin
                    owner_vld = 1'b1;
                    owner     = 1'b1;
                end
            end
        endcase
    end

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign owner_read = owner ? s1_read : s0_read;

    // A return in the same cycle frees a slot, so a full FIFO may still accept.
    assign m_read       = ~rst & owner_vld & owner_read & ~(full & ~m_readdatavalid);
    assign m_address    = owner ? s1_address : s0_address;
    assign m_byteenable = owner ? s1_byteenable : s0_byteenable;
    assign accept       = m_read & ~m_waitrequest;

    assign s0_waitrequest = ~(accept & ~owner);
    assign s1_waitrequest = ~(accept & owner);

    assign pop              = m_readdatavalid & ~empty;
    assign head             = tag_q[rd_ptr_q];
    assign s0_readdatavalid = pop & ~head;
    assign s1_readdatavalid = pop & head;
    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;

    assign pending    = count_q;
    assign err_orphan = err_q;
    assign arb_state  = state_q;

    always_comb begin
        state_d = UNLOCKED;
        last_d  = last_q;
        if (accept) begin
            last_d = owner;
        end else if (m_read && m_waitrequest) begin
            state_d = owner ? LOCK1 : LOCK0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            last_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            if (accept) begin
                tag_q[wr_ptr_q] <= owner;
                wr_ptr_q        <= wr_ptr_q + PEND_LOG'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PEND_LOG'(1);
            end
            if (accept && !pop) begin
                count_q <= count_q + (PEND_LOG+1)'(1);
            end else if (!accept && pop) begin
                count_q <= count_q - (PEND_LOG+1)'(1);
            end
            if (m_readdatavalid && empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_osd_read_arbiter.sv
// Self-checking bench for osd_read_arbiter: reference arbitration model plus an
// in-order scoreboard of {requester, data} for every accepted read.
module tb_osd_read_arbiter;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s0_address = '0, s1_address = '0, m_address;
    logic        s0_read = 1'b0, s1_read = 1'b0;
    logic [0:0]  s0_byteenable = 1'b1, s1_byteenable = 1'b1, m_byteenable;
    logic        s0_waitrequest, s1_waitrequest;
    logic [7:0]  s0_readdata, s1_readdata;
    logic        s0_readdatavalid, s1_readdatavalid;
    logic        m_read;
    logic        m_waitrequest = 1'b0;
    logic [7:0]  m_readdata = '0;
    logic        m_readdatavalid = 1'b0;
    logic [3:0]  pending;
    logic        err_orphan;
    logic [1:0]  arb_state;

    int          vectors = 0;
    int          miscompares = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  ret_q[$];
    int          mlock = 0;
    bit          mlast = 1'b1;
    bit          merr = 1'b0;
    bit          acc0 = 1'b0, acc1 = 1'b0;
    int          want0 = 0, want1 = 0;

    osd_read_arbiter #(.DATA_LOG(3), .PEND_LOG(3)) dut (
        .clk(clk), .rst(rst),
        .s0_address(s0_address), .s0_read(s0_read), .s0_byteenable(s0_byteenable),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_byteenable(s1_byteenable),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
        .s1_readdatavalid(s1_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .pending(pending), .err_orphan(err_orphan), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] data_of(input logic [31:0] a);
        return a[9:2] ^ 8'h1A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of one cycle, evaluated on the falling edge.
    task automatic model_check();
        bit         ov, ow, oread, full, mr, acc, r0, r1;
        logic [8:0] e;
        logic [31:0] a;
        ov = 1'b0;
        ow = 1'b0;
        if (mlock == 1) begin ov = 1'b1; ow = 1'b0; end
        else if (mlock == 2) begin ov = 1'b1; ow = 1'b1; end
        else if (s0_read && s1_read) begin ov = 1'b1; ow = ~mlast; end
        else if (s0_read) begin ov = 1'b1; ow = 1'b0; end
        else if (s1_read) begin ov = 1'b1; ow = 1'b1; end
        oread = ow ? s1_read : s0_read;
        full  = (exp_q.size() == DEPTH) && !m_readdatavalid;
        mr    = ov && oread && !full;
        acc   = mr && !m_waitrequest;
        a     = ow ? s1_address : s0_address;
        check("arb_state", 32'(arb_state), 32'(mlock));
        check("m_read", 32'(m_read), 32'(mr));
        if (mr) begin
            check("m_address", m_address, a);
            check("m_byteenable", 32'(m_byteenable), 32'(ow ? s1_byteenable : s0_byteenable));
        end
        check("s0_waitrequest", 32'(s0_waitrequest), 32'(!(acc && !ow)));
        check("s1_waitrequest", 32'(s1_waitrequest), 32'(!(acc && ow)));
        check("pending", 32'(pending), 32'(exp_q.size()));
        check("err_orphan", 32'(err_orphan), 32'(merr));
        r0 = 1'b0;
        r1 = 1'b0;
        if (m_readdatavalid) begin
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                r0 = !e[8];
                r1 = e[8];
                check("s0_readdata", 32'(s0_readdata), 32'(e[7:0]));
                check("s1_readdata", 32'(s1_readdata), 32'(e[7:0]));
            end else begin
                merr = 1'b1;
            end
        end
        check("s0_readdatavalid", 32'(s0_readdatavalid), 32'(r0));
        check("s1_readdatavalid", 32'(s1_readdatavalid), 32'(r1));
        acc0 = acc && !ow;
        acc1 = acc && ow;
        if (acc) begin
            exp_q.push_back({ow, data_of(a)});
            ret_q.push_back(data_of(a));
            mlast = ow;
            mlock = 0;
        end else if (mr) begin
            mlock = ow ? 2 : 1;
        end else begin
            mlock = 0;
        end
    endtask

    // Requesters hold read/address until accepted, then optionally issue a new one.
    task automatic req_update();
        if (acc0 || !s0_read) begin
            s0_read = ($urandom_range(1, 100) <= want0);
            if (s0_read) begin
                s0_address    = $urandom() & 32'h0000_FFFC;
                s0_byteenable = 1'($urandom_range(0, 1));
            end
        end
        if (acc1 || !s1_read) begin
            s1_read = ($urandom_range(1, 100) <= want1);
            if (s1_read) begin
                s1_address    = $urandom() & 32'h0000_FFFC;
                s1_byteenable = 1'($urandom_range(0, 1));
            end
        end
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    task automatic cycle(input bit wr, input bit ret);
        req_update();
        m_waitrequest = wr;
        if (ret) begin
            m_readdatavalid = 1'b1;
            if (ret_q.size() > 0) m_readdata = ret_q.pop_front();
            else                  m_readdata = 8'($urandom_range(0, 255));
        end else begin
            m_readdatavalid = 1'b0;
        end
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        s0_read = 1'b0;
        s1_read = 1'b0;
        m_readdatavalid = 1'b0;
        m_waitrequest = 1'b0;
        mlock = 0;
        mlast = 1'b1;
        merr  = 1'b0;
        acc0  = 1'b0;
        acc1  = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_m_read", 32'(m_read), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_err_orphan", 32'(err_orphan), 32'd0);
        check("rst_s0_waitrequest", 32'(s0_waitrequest), 32'd1);
        check("rst_s1_waitrequest", 32'(s1_waitrequest), 32'd1);
        check("rst_arb_state", 32'(arb_state), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        want0 = 0;
        want1 = 0;
        for (int i = 0; i < 80 && (ret_q.size() > 0 || s0_read || s1_read); i++) begin
            cycle(1'b0, ret_q.size() > 0);
        end
        cycle(1'b0, 1'b0);
        check("drain_pending", 32'(pending), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apply_reset();

        // Single requester, fixed address, return three cycles later.
        want0 = 0;
        want1 = 0;
        s0_read = 1'b1;
        s0_address = 32'h0000_0100;
        s0_byteenable = 1'b1;
        cycle(1'b0, 1'b0);
        check("t1_pending_after_accept", 32'(pending), 32'd1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("t1_pending_after_return", 32'(pending), 32'd0);

        // Both requesting continuously: alternating grants starting with 0.
        apply_reset();
        want0 = 100;
        want1 = 100;
        for (int i = 0; i < 10; i++) cycle(1'b0, ret_q.size() > 0 && $urandom_range(0, 1) == 1);
        drain();

        // Waitrequest held for 4 cycles locks requester 0.
        apply_reset();
        want0 = 100;
        want1 = 100;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        drain();

        // Fill the tag FIFO, then accept alongside a return while full.
        want0 = 100;
        want1 = 100;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check("t4_pending_full", 32'(pending), 32'd8);
        cycle(1'b0, 1'b1);
        check("t4_pending_still_full", 32'(pending), 32'd8);
        drain();

        // Random traffic with random stalls and returns.
        want0 = 60;
        want1 = 60;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 3) == 0, ret_q.size() > 0 && $urandom_range(0, 2) != 0);
        end
        drain();

        // Orphan return sets the sticky error until reset.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        check("t5_err_sticky", 32'(err_orphan), 32'd1);
        apply_reset();

        // Asynchronous reset with three reads outstanding.
        want0 = 100;
        want1 = 100;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        check("t6_pending_before_rst", 32'(pending), 32'd3);
        rst = 1'b1;
        #1;
        check("t6_async_m_read", 32'(m_read), 32'd0);
        check("t6_async_pending", 32'(pending), 32'd0);
        check("t6_async_s0_wait", 32'(s0_waitrequest), 32'd1);
        check("t6_async_s1_wait", 32'(s1_waitrequest), 32'd1);
        want0 = 0;
        want1 = 0;
        s0_read = 1'b0;
        s1_read = 1'b0;
        mlock = 0;
        mlast = 1'b1;
        merr  = 1'b0;
        acc0  = 1'b0;
        acc1  = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("t6_err_orphan", 32'(err_orphan), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
